mem_bus_arbiter: RTL and testbench

Two-master arbiter for the native picorv32-style memory bus (valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb). It sits between the CPU and the address decoder. Master 0 is the CPU and master 1 is a DMA/LCD-fill engine, and both share one slave-side port.
- Arbitration is round-robin.
- A grant is locked for the whole transaction.
- A watchdog terminates any transfer the slave never acknowledges and records the error.

---
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter that lets two native valid/ready memory masters
//   (m0 = CPU, m1 = DMA/LCD-fill engine) share one slave-side port.
//   A grant is held for the whole transaction. A watchdog ends any transfer
//   the slave never acknowledges: the master gets a ready pulse carrying
//   ERR_DATA, and the error is recorded in err/err_addr.
//
// Ports
//   clk, reset                 system clock, async active-high reset
//   mN_valid/addr/wdata/wstrb  master N request (wstrb == 0 means read)
//   mN_ready/rdata             master N completion pulse and read data
//   s_valid/addr/wdata/wstrb   slave-side request
//   s_ready/rdata              slave-side completion and read data
//   err, err_addr, err_clr     sticky timeout flag, first timeout address, clear
//
// States
//   IDLE   | no grant; arbitrate between the pending requests
//   GRANT0 | m0 owns the slave port until ready, timeout or a dropped valid
//   GRANT1 | m1 owns the slave port until ready, timeout or a dropped valid

module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;       // master that completed most recently
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        granted;
  logic        sel;                  // 1 when m1 owns the port
  logic        gnt_valid;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic [3:0]  gnt_wstrb;
  logic        timer_hit;            // watchdog expires this cycle

  // Owner mux. Ready and timeout do not look at the master's valid, so
  // there is no combinational path from mN_valid to mN_ready.
  always_comb begin
    granted   = (state_q == GRANT0) || (state_q == GRANT1);
    sel       = (state_q == GRANT1);
    gnt_valid = granted && (sel ? m1_valid : m0_valid);
    gnt_addr  = sel ? m1_addr  : m0_addr;
    gnt_wdata = sel ? m1_wdata : m0_wdata;
    gnt_wstrb = sel ? m1_wstrb : m0_wstrb;
    timer_hit = granted && !s_ready && (timer_q == TIMER_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      timer_q    <= 16'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    timer_d    = timer_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    // A timeout below overrides a clear in the same cycle.
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (m0_valid && m1_valid) state_d = last_q ? GRANT0 : GRANT1;
        else if (m0_valid)        state_d = GRANT0;
        else if (m1_valid)        state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (s_ready) begin
          state_d = IDLE;
          last_d  = sel;
          timer_d = 16'd0;
        end else if (timer_hit) begin
          state_d = IDLE;
          last_d  = sel;
          timer_d = 16'd0;
          err_d   = 1'b1;
          if (!err_q) err_addr_d = gnt_addr;
        end else if (!gnt_valid) begin
          // Master abandoned its request: no pulse, fairness untouched.
          state_d = IDLE;
          timer_d = 16'd0;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    s_wstrb  = 4'd0;
    m0_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_ready = 1'b0;
    m1_rdata = 32'd0;

    if (granted) begin
      // The slave request is withdrawn on the timeout cycle so a late
      // ready cannot be mistaken for this transfer's completion.
      s_valid = gnt_valid && !timer_hit;
      s_addr  = gnt_addr;
      s_wdata = gnt_wdata;
      s_wstrb = gnt_wstrb;
      if (sel) begin
        m1_ready = s_ready || timer_hit;
        m1_rdata = timer_hit ? ERR_DATA : s_rdata;
      end else begin
        m0_ready = s_ready || timer_hit;
        m0_rdata = timer_hit ? ERR_DATA : s_rdata;
      end
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared against a transaction-level reference model that
//   tracks the current owner, the cycles it has waited, the round-robin
//   pointer and the error record.

module tb_mem_bus_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  mem_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: owner (-1 = nobody), cycles waited, last winner, error record
  int          cur;
  int          waited;
  bit          mlast;
  bit          merr;
  logic [31:0] merr_addr;

  // values captured by the last step
  bit          exp_r [2];
  bit          o_sv, o_m0r, o_m1r, o_err;
  logic [31:0] o_m0d, o_m1d, o_sa, o_sd, o_erra;
  logic [3:0]  o_ss;

  task automatic model_reset();
    cur = -1; waited = 0; mlast = 1'b1; merr = 1'b0; merr_addr = 32'd0;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0; err_clr = 0;
  endtask

  task automatic setm(input int k, input bit v, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    if (k == 0) begin m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
    else        begin m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".s_valid"},  32'(s_valid),  0);
    chk({tag, ".s_addr"},   s_addr,        0);
    chk({tag, ".s_wdata"},  s_wdata,       0);
    chk({tag, ".s_wstrb"},  32'(s_wstrb),  0);
    chk({tag, ".m0_ready"}, 32'(m0_ready), 0);
    chk({tag, ".m1_ready"}, 32'(m1_ready), 0);
    chk({tag, ".m0_rdata"}, m0_rdata,      0);
    chk({tag, ".m1_rdata"}, m1_rdata,      0);
    chk({tag, ".err"},      32'(err),      0);
    chk({tag, ".err_addr"}, err_addr,      0);
  endtask

  // Entered just after a negedge with inputs applied; checks, advances the
  // model over the next posedge and returns at the following negedge.
  task automatic step();
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];
    logic        er [2];
    logic [31:0] erd [2];
    logic        ev;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    bit          hit, sr, nerr;
    #1;
    v[0] = m0_valid; a[0] = m0_addr; d[0] = m0_wdata; s[0] = m0_wstrb;
    v[1] = m1_valid; a[1] = m1_addr; d[1] = m1_wdata; s[1] = m1_wstrb;
    sr = s_ready;
    ev = 0; ea = 0; ed = 0; es = 0; hit = 0;
    er[0] = 0; er[1] = 0; erd[0] = 0; erd[1] = 0;
    if (cur >= 0) begin
      hit      = (waited == TO - 1) && !sr;
      ev       = v[cur] && !hit;
      ea       = a[cur]; ed = d[cur]; es = s[cur];
      er[cur]  = sr || hit;
      erd[cur] = hit ? ERRD : s_rdata;
    end
    chk("s_valid",  32'(s_valid),  32'(ev));
    chk("s_addr",   s_addr,        ea);
    chk("s_wdata",  s_wdata,       ed);
    chk("s_wstrb",  32'(s_wstrb),  32'(es));
    chk("m0_ready", 32'(m0_ready), 32'(er[0]));
    chk("m1_ready", 32'(m1_ready), 32'(er[1]));
    if (er[0] || cur != 0) chk("m0_rdata", m0_rdata, erd[0]);
    if (er[1] || cur != 1) chk("m1_rdata", m1_rdata, erd[1]);
    chk("err",      32'(err),      32'(merr));
    chk("err_addr", err_addr,      merr_addr);
    exp_r[0] = er[0]; exp_r[1] = er[1];
    o_sv = s_valid; o_sa = s_addr; o_sd = s_wdata; o_ss = s_wstrb;
    o_m0r = m0_ready; o_m0d = m0_rdata; o_m1r = m1_ready; o_m1d = m1_rdata;
    o_err = err; o_erra = err_addr;

    @(posedge clk);
    nerr = err_clr ? 1'b0 : merr;
    if (cur < 0) begin
      if (v[0] && v[1]) cur = mlast ? 0 : 1;
      else if (v[0])    cur = 0;
      else if (v[1])    cur = 1;
      waited = 0;
    end else if (sr) begin
      mlast = (cur == 1); cur = -1; waited = 0;
    end else if (hit) begin
      nerr = 1'b1;
      if (!merr) merr_addr = a[cur];
      mlast = (cur == 1); cur = -1; waited = 0;
    end else if (!v[cur]) begin
      cur = -1; waited = 0;
    end else if (waited < 65535) begin
      waited++;
    end
    merr = nerr;
    @(negedge clk);
  endtask

  initial begin
    int order [$];
    bit req [2];

    reset = 1'b1;
    idle_inputs();
    model_reset();
    exp_r[0] = 0; exp_r[1] = 0;
    @(negedge clk);
    chk_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    chk_zero("after_reset");

    // simultaneous requests straight after reset, zero-wait slave
    setm(0, 1, 32'h0000_0100, 32'h0, 4'h0);
    setm(1, 1, 32'h0000_0200, 32'h0, 4'h0);
    s_ready = 1; s_rdata = 32'hA5A5_0000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_m0r) order.push_back(0);
      if (o_m1r) order.push_back(1);
    end
    chk("dual_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dual_order%0d", i), (i < order.size()) ? order[i] : 99, i % 2);
    idle_inputs();
    step();

    // single m0 read, three wait cycles
    setm(0, 1, 32'h0002_0010, 32'h0, 4'h0);
    step();
    chk("t1_idle_svalid", 32'(o_sv), 0);
    step();
    chk("t1_svalid_rise", 32'(o_sv), 1);
    step();
    step();
    s_ready = 1; s_rdata = 32'h1234_5678;
    step();
    chk("t1_m0_ready", 32'(o_m0r), 1);
    chk("t1_m0_rdata", o_m0d, 32'h1234_5678);
    chk("t1_m1_ready", 32'(o_m1r), 0);
    idle_inputs();
    step();
    chk("t1_no_second", 32'(o_m0r), 0);

    // m1 write pass-through
    setm(1, 1, 32'h8000_0000, 32'h0000_00AA, 4'b0001);
    step();
    step();
    chk("wr_s_valid", 32'(o_sv), 1);
    chk("wr_s_addr",  o_sa, 32'h8000_0000);
    chk("wr_s_wdata", o_sd, 32'h0000_00AA);
    chk("wr_s_wstrb", 32'(o_ss), 32'h1);
    s_ready = 1;
    step();
    chk("wr_m1_ready", 32'(o_m1r), 1);
    idle_inputs();
    step();

    // timeout: slave never answers
    setm(0, 1, 32'h0000_4000, 32'h0, 4'h0);
    step();
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) chk("to_no_early_ready", 32'(o_m0r), 0);
      step();
    end
    chk("to_m0_ready", 32'(o_m0r), 1);
    chk("to_m0_rdata", o_m0d, ERRD);
    chk("to_s_valid",  32'(o_sv), 0);
    idle_inputs();
    step();
    chk("to_err", 32'(o_err), 1);
    chk("to_err_addr", o_erra, 32'h0000_4000);

    setm(1, 1, 32'h0000_5000, 32'h1, 4'hF);
    step();
    for (int i = 0; i < TO; i++) step();
    chk("to2_m1_ready", 32'(o_m1r), 1);
    chk("to2_m1_rdata", o_m1d, ERRD);
    idle_inputs();
    step();
    chk("to2_err_addr_kept", o_erra, 32'h0000_4000);
    err_clr = 1;
    step();
    err_clr = 0;
    step();
    chk("clr_err", 32'(o_err), 0);
    chk("clr_err_addr_kept", o_erra, 32'h0000_4000);

    // ready exactly on the last watchdog cycle
    setm(0, 1, 32'h0000_6000, 32'h0, 4'h0);
    step();
    for (int i = 0; i < TO - 1; i++) step();
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    step();
    chk("bnd_m0_ready", 32'(o_m0r), 1);
    chk("bnd_m0_rdata", o_m0d, 32'hCAFE_0001);
    idle_inputs();
    step();
    chk("bnd_err", 32'(o_err), 0);

    // reset while m1 waits
    setm(1, 1, 32'h0000_7000, 32'h0, 4'h0);
    step();
    step();
    step();
    #2;
    chk("mid_pre_s_valid", 32'(s_valid), 1);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    setm(0, 1, 32'h0000_0100, 32'h0, 4'h0);
    setm(1, 1, 32'h0000_0200, 32'h0, 4'h0);
    s_ready = 1;
    step();
    step();
    chk("mid_m0_first", 32'(o_m0r), 1);
    chk("mid_m1_waits", 32'(o_m1r), 0);
    idle_inputs();
    step();

    // randomized traffic
    req[0] = 0; req[1] = 0;
    exp_r[0] = 0; exp_r[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (req[k] && exp_r[k]) begin
          req[k] = 0;
        end else if (!req[k] && ($urandom % 3 == 0)) begin
          req[k] = 1;
          setm(k, 1, $urandom, $urandom, 4'($urandom_range(15)));
        end else if (req[k] && ($urandom % 64 == 0)) begin
          req[k] = 0;
        end
        if (k == 0) m0_valid = req[0];
        else        m1_valid = req[1];
      end
      s_ready = ($urandom % 5 == 0);
      s_rdata = $urandom;
      err_clr = ($urandom % 40 == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
